// File: rtl/audio_uart_tx_arb.sv
`default_nettype none
// =============================================================================
//  Module      : audio_uart_tx_arb
//  Description : Round-robin, message-granular arbiter sharing one UART TX line
//                between NUM_REQ fabric requesters, with a built-in baud shifter.
//                Define AUDIO_TX_PARITY_EN for 8E1 framing (default 8N1).
//  Revision    : 1.0 - initial release
// =============================================================================
module audio_uart_tx_arb #(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = 434,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 txd_o,
    output logic                 busy_o,
    output logic                 timeout_err_o
);

`ifdef AUDIO_TX_PARITY_EN
    localparam int c_SHIFT_W = 10;
`else
    localparam int c_SHIFT_W = 9;
`endif
    localparam int c_PTR_W  = $clog2(NUM_REQ);
    localparam int c_BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W  = 4;
    localparam int c_TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(c_SHIFT_W);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_PTR_W-1:0]  c_PTR_MAX   = c_PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOCK  = 2'd1,
        S_SHIFT = 2'd2
    } state_e;

    state_e                 state_q;
    logic [c_PTR_W-1:0]     ptr_q;
    logic [c_PTR_W-1:0]     g_idx_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [NUM_REQ-1:0]     ready_q;
    logic                   txd_q;
    logic                   err_q;
    logic                   last_q;
    logic [c_BAUD_W-1:0]    baud_q;
    logic [c_BIT_W-1:0]     bit_q;
    logic [c_TO_W-1:0]      idle_q;
    logic [c_SHIFT_W-1:0]   shift_q;

    logic [c_PTR_W-1:0]     w_scan;
    logic [c_PTR_W-1:0]     w_sel_idx;
    logic                   w_sel_found;
    logic [NUM_REQ-1:0]     w_sel_oh;
    logic [c_PTR_W-1:0]     w_ptr_next;
    logic [7:0]             w_g_data;
    logic                   w_g_last;
    logic                   w_accept;
    logic [c_SHIFT_W-1:0]   w_load;

    // First valid requester at or after the rotating pointer, wrapping around.
    always_comb begin
        w_scan      = '0;
        w_sel_idx   = '0;
        w_sel_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = c_PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!w_sel_found && req_valid_i[w_scan]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_scan;
            end
        end
    end

    assign w_sel_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
    assign w_ptr_next = (g_idx_q == c_PTR_MAX) ? '0 : g_idx_q + 1'b1;
    assign w_g_data   = req_data_i[{g_idx_q, 3'b000} +: 8];
    assign w_g_last   = req_last_i[g_idx_q];
    assign w_accept   = |(req_valid_i & ready_q);

`ifdef AUDIO_TX_PARITY_EN
    assign w_load = {1'b1, ^w_g_data, w_g_data};
`else
    assign w_load = {1'b1, w_g_data};
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            g_idx_q <= '0;
            grant_q <= '0;
            ready_q <= '0;
            txd_q   <= 1'b1;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            idle_q  <= '0;
            shift_q <= '1;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_sel_found) begin
                        g_idx_q <= w_sel_idx;
                        grant_q <= w_sel_oh;
                        ready_q <= w_sel_oh;
                        state_q <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (w_accept) begin
                        ready_q <= '0;
                        last_q  <= w_g_last;
                        shift_q <= w_load;
                        txd_q   <= 1'b0;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        idle_q  <= '0;
                        state_q <= S_SHIFT;
                    end else if (TIMEOUT != 0) begin
                        if (idle_q == c_TO_LAST) begin
                            grant_q <= '0;
                            ready_q <= '0;
                            ptr_q   <= w_ptr_next;
                            err_q   <= 1'b1;
                            idle_q  <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (baud_q == c_BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == c_BIT_LAST) begin
                            // Stop bit finished; txd_q is already high.
                            if (last_q) begin
                                grant_q <= '0;
                                ptr_q   <= w_ptr_next;
                                state_q <= S_IDLE;
                            end else begin
                                ready_q <= grant_q;
                                state_q <= S_LOCK;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            txd_q   <= shift_q[0];
                            shift_q <= {1'b1, shift_q[c_SHIFT_W-1:1]};
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o   = ready_q;
    assign grant_o       = grant_q;
    assign txd_o         = txd_q;
    assign busy_o        = (state_q != S_IDLE);
    assign timeout_err_o = err_q;

endmodule
`default_nettype wire

// File: doc/audio_uart_tx_arb.md
Name: audio_uart_tx_arb

Overview:
- Fabric-side arbiter and serializer that shares one UART transmit line (routed to the MSS UART_1_RXD path or an external pin) between NUM_REQ fabric requesters, such as the audio-description message generator, the GPI event reporter and the debug logger.
- Arbitration is message-granular: a requester keeps the line from its first byte through the byte flagged LAST, so messages never interleave.
- Grants rotate round-robin. The block contains its own 8N1 baud-timed shifter.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- CLK_DIV, 434: clock cycles per UART bit (50 MHz / 115200).
- TIMEOUT, 1024: cycles the granted requester may hold VALID low mid-message before the grant is revoked. 0 disables the timeout.

Ports:
- CLK  input  1  fabric clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ_VALID  input  NUM_REQ  per-requester byte valid.
- REQ_DATA  input  8*NUM_REQ  byte of requester i at [8i+7:8i].
- REQ_LAST  input  NUM_REQ  byte is the last of its message.
- REQ_READY  output  NUM_REQ  byte accepted when VALID and READY are both high.
- GRANT  output  NUM_REQ  one-hot owner of the line; 0 when free.
- TXD  output  1  serial output, idle high.
- BUSY  output  1  high whenever state is not IDLE.
- TIMEOUT_ERR  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset values: GRANT=0, REQ_READY=0, TXD=1, BUSY=0, TIMEOUT_ERR=0, rr pointer=0, state=IDLE, counters=0.
- Reset asserted mid-frame aborts the frame. TXD is 1 on the cycle after RESET is sampled.
- IDLE state:
  - If any REQ_VALID is high, select the first set bit scanning from pointer upward and wrapping modulo NUM_REQ.
  - GRANT is registered and state goes to LOCK.
  - Arbitration takes 1 cycle. Bytes offered in IDLE are not accepted.
- LOCK state:
  - REQ_READY[g] = 1 for the granted g only. All other READY bits are 0 at all times.
  - On VALID[g] & READY[g]: latch the data and LAST, clear the idle counter, and go to SHIFT. The start bit appears on TXD the next cycle.
  - While VALID[g] is low, the idle counter increments. When it reaches TIMEOUT (and TIMEOUT≠0): GRANT←0, pointer←(g+1) mod NUM_REQ, TIMEOUT_ERR pulses, and state goes to IDLE.
- SHIFT state:
  - Frame bits are: start(0), D0..D7 LSB first, stop(1). Each bit is held exactly CLK_DIV cycles, counted by the baud counter 0..CLK_DIV-1.
  - After the last stop-bit cycle:
    - If LAST was latched: GRANT←0, pointer←(g+1) mod NUM_REQ, state goes to IDLE.
    - Otherwise state goes to LOCK.
- Frame spacing:
  - Back-to-back bytes within a message are separated by exactly 1 idle-high cycle: the LOCK accept cycle.
  - Between messages the idle gap is 2 cycles minimum (IDLE, then the LOCK accept).
- Requester behaviour:
  - A requester dropping VALID while not granted has no effect.
  - VALID and LAST on a non-granted requester are ignored.
  - Changing REQ_DATA while VALID is high and READY is low is legal. The data is sampled only at acceptance.
- Simultaneous events:
  - When all requesters are valid, grants rotate 0,1,2,3,0… one message each.
  - A lone requester is re-granted immediately: the pointer wraps to it.
- The timeout counter does not run in SHIFT or IDLE.

Optional Feature:
- Macro AUDIO_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of D0..D7) is inserted between D7 and the stop bit. The frame is 11 bits (8E1), 11*CLK_DIV cycles.
- Undefined: 8N1 frame, 10*CLK_DIV cycles, and no parity logic is synthesized.

Test Plan:
- All tests use CLK_DIV=4 and TIMEOUT=16.
- Single byte:
  - Stimulus: requester 0 sends 0xA5 with LAST.
  - Required: TXD sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - Required: GRANT=0001 from arbitration to stop-bit end, then GRANT=0.
- Round-robin:
  - Stimulus: requesters 0–3 each post a 2-byte message simultaneously.
  - Required: the line is granted 0,1,2,3 in order with no interleaving.
  - Required: each intra-message gap is exactly 1 high cycle.
- Timeout:
  - Stimulus: requester 2 sends 0x11 without LAST, then holds VALID low.
  - Required: 16 cycles after entering LOCK, TIMEOUT_ERR pulses once, GRANT goes to 0, and the next arbitration starts from requester 3.
- Reset mid-frame:
  - Stimulus: assert RESET during D3 of a frame.
  - Required: next cycle TXD=1, GRANT=0, BUSY=0, REQ_READY=0.
  - Required: the following arbitration starts at requester 0.
- Parity, built with AUDIO_TX_PARITY_EN defined:
  - Stimulus: send 0x07.
  - Required: parity bit 1, frame is 44 cycles.
  - Stimulus: send 0x03.
  - Required: parity bit 0.
